pe_slave_rr_arbiter: RTL

Per-slave request arbiter for the peripheral interconnect. One instance per peripheral port collects the per-slave request bits and payloads driven by the N_MASTER PE request address decoders. It selects one master per cycle with a round-robin policy and forwards the winner through a single-entry registered output slot to the peripheral, using a req/gnt handshake. The forwarded ID lets the response path route read data back to the originating master.

---
 rtl/pe_slave_rr_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pe_slave_rr_arbiter.sv
// pe_slave_rr_arbiter: per-slave round-robin arbiter with a single-entry
// registered output slot and req/gnt handshake towards the peripheral.
// Optional feature macro: PE_ARB_CONFLICT_CNT_EN adds conflict_cnt_o, a
// saturating count of cycles in which two or more masters request.
module pe_slave_rr_arbiter #(
    parameter int N_MASTER   = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = N_MASTER
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_MASTER-1:0]                  data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]                  data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
    input  logic [N_MASTER-1:0][ID_WIDTH-1:0]    data_ID_i,
    output logic [N_MASTER-1:0]                  data_gnt_o,
    output logic                                 data_req_o,
    output logic [ADDR_WIDTH-1:0]                data_add_o,
    output logic                                 data_wen_o,
    output logic [DATA_WIDTH-1:0]                data_wdata_o,
    output logic [BE_WIDTH-1:0]                  data_be_o,
    output logic [ID_WIDTH-1:0]                  data_ID_o,
    input  logic                                 data_gnt_i
`ifdef PE_ARB_CONFLICT_CNT_EN
    ,
    output logic [31:0]                          conflict_cnt_o
`endif
);

    // Pointer width; a single master still needs one bit to hold index 0.
    localparam int RR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    logic                  valid_reg;
    logic [RR_W-1:0]       rr_reg;
    logic [RR_W-1:0]       rr_next;
    logic [ADDR_WIDTH-1:0] add_reg;
    logic                  wen_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [BE_WIDTH-1:0]   be_reg;
    logic [ID_WIDTH-1:0]   id_reg;

    logic                  slot_free;
    logic                  accept;
    logic                  win_found;
    logic [RR_W-1:0]       win_idx;
    logic [RR_W-1:0]       win_dist;

    // Distance of each master from the pointer, counted upward with an
    // explicit wrap past N_MASTER-1 (no modulo, N_MASTER may be any size).
    logic [N_MASTER-1:0][RR_W-1:0] req_dist;

    // The slot can take a new entry when empty or when it drains this cycle.
    assign slot_free = !valid_reg || data_gnt_i;
    assign accept    = rst_n && slot_free && win_found;

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_dist
            assign req_dist[gi] = (RR_W'(gi) >= rr_reg)
                                ? (RR_W'(gi) - rr_reg)
                                : (RR_W'(gi) + RR_W'(N_MASTER) - rr_reg);
        end
    endgenerate

    // Winner is the requesting master closest to the pointer going upward.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_dist  = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            if (data_req_i[m] && (!win_found || (req_dist[m] < win_dist))) begin
                win_found = 1'b1;
                win_idx   = RR_W'(m);
                win_dist  = req_dist[m];
            end
        end
    end

    // Pointer moves just past the winner, wrapping to 0 after the last master.
    assign rr_next = (win_idx == RR_W'(N_MASTER - 1)) ? '0 : (win_idx + RR_W'(1));

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_gnt
            assign data_gnt_o[gi] = accept && (win_idx == RR_W'(gi));
        end
    endgenerate

    // Output slot: load the winner on accept, empty it on a bare drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            rr_reg    <= '0;
            add_reg   <= '0;
            wen_reg   <= 1'b0;
            wdata_reg <= '0;
            be_reg    <= '0;
            id_reg    <= '0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            rr_reg    <= rr_next;
            add_reg   <= data_add_i[win_idx];
            wen_reg   <= data_wen_i[win_idx];
            wdata_reg <= data_wdata_i[win_idx];
            be_reg    <= data_be_i[win_idx];
            id_reg    <= data_ID_i[win_idx];
        end else if (valid_reg && data_gnt_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign data_req_o   = valid_reg;
    assign data_add_o   = add_reg;
    assign data_wen_o   = wen_reg;
    assign data_wdata_o = wdata_reg;
    assign data_be_o    = be_reg;
    assign data_ID_o    = id_reg;

`ifdef PE_ARB_CONFLICT_CNT_EN
    logic [31:0] conflict_cnt_reg;
    logic        multi_req;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_req = |(data_req_i & (data_req_i - N_MASTER'(1)));

    // Saturating count of contended cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt_reg <= '0;
        end else if (multi_req && (conflict_cnt_reg != 32'hFFFF_FFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_reg;
`endif

endmodule
